// File: rtl/calc_pkg.sv
// Shared definitions for the signed calculator arithmetic unit.
package calc_pkg;

  // Default operand width shared by the adder and subtractor paths
  localparam int unsigned CALC_WIDTH = 8;

  // Sequencer states shared by the bit-serial arithmetic blocks
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } calc_state_t;

endpackage : calc_pkg

// File: rtl/serial_signed_adder_full_adder.sv
// Gate-level full-adder cell for the bit-serial adder: two half adders and an OR.

// Half adder: sum and carry of two bits
module half_adder (
  output logic s,
  output logic c,
  input  logic a,
  input  logic b
);

  assign s = a ^ b;
  assign c = a & b;

endmodule : half_adder

// Full adder with outputs forced low while reset (active-low) is asserted
module full_adder (
  output logic sum,
  output logic cout,
  input  logic a,
  input  logic b,
  input  logic cin,
  input  logic rst
);

  logic w_s0;
  logic w_c0;
  logic w_s1;
  logic w_c1;
  logic w_cout;

  half_adder u_ha0 (
    .s (w_s0),
    .c (w_c0),
    .a (a),
    .b (b)
  );

  half_adder u_ha1 (
    .s (w_s1),
    .c (w_c1),
    .a (w_s0),
    .b (cin)
  );

  assign w_cout = w_c0 | w_c1;

  // Reset gating keeps the cell quiet while the sequencer is held in reset
  assign sum  = w_s1   & rst;
  assign cout = w_cout & rst;

endmodule : full_adder

// File: rtl/serial_signed_adder.sv
// Bit-serial two's-complement adder: one full-adder cell, one carry flop,
// WIDTH clocks per operation, LSB first.
module serial_signed_adder
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH = CALC_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int unsigned CW = $clog2(WIDTH);

  calc_state_t      r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;

  logic             w_sum_bit;
  logic             w_cout;
  logic [WIDTH-1:0] w_res_next;

  full_adder u_fa (
    .sum  (w_sum_bit),
    .cout (w_cout),
    .a    (r_a[0]),
    .b    (r_b[0]),
    .cin  (r_carry),
    .rst  (rst)
  );

  // Result register shifts right with each new sum bit entering at the MSB
  assign w_res_next = {w_sum_bit, r_res[WIDTH-1:1]};

  // Sequencer, datapath shift registers and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_res   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            busy    <= 1'b1;
            r_state <= RUN;
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_res   <= w_res_next;
          r_carry <= w_cout;
          r_cnt   <= r_cnt + CW'(1);
          if (r_cnt == CW'(WIDTH - 1)) begin
            // r_carry here is still the carry into the MSB
            sum      <= w_res_next;
            carry    <= w_cout;
            overflow <= r_carry ^ w_cout;
            busy     <= 1'b0;
            done     <= 1'b1;
            r_state  <= DONE;
          end
        end
        default: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule : serial_signed_adder
